led_pwm_blink_driver: RTL

- Downstream stage of the LED output PIO. Consumes the PIO's 8-bit LED pattern and drives the physical LED pins.
- Applies a global PWM brightness to all lit LEDs.
- Applies a per-LED blink mask with a programmable blink rate.
- Configured by the Nios II CPU through its own small Avalon-MM slave, with zero-wait-state, latency-0 reads.

---
 rtl/led_drv_pkg.sv | 18 +
 rtl/led_pwm_timebase.sv | 57 +++++
 rtl/led_pwm_blink_driver.sv | 99 +++++++++
 3 files changed

// File: rtl/led_drv_pkg.sv
// Shared constants for the LED PWM/blink driver: register addresses, reset values
// and STATUS field positions.
package led_drv_pkg;

    localparam logic [1:0] ADDR_DUTY       = 2'd0;
    localparam logic [1:0] ADDR_BLINK_DIV  = 2'd1;
    localparam logic [1:0] ADDR_BLINK_MASK = 2'd2;
    localparam logic [1:0] ADDR_STATUS     = 2'd3;

    // Held at full bus width; each register takes its own low slice.
    localparam logic [31:0] DUTY_RST       = '1;
    localparam logic [31:0] BLINK_DIV_RST  = '0;
    localparam logic [31:0] BLINK_MASK_RST = '0;

    localparam int PHASE_BIT = 0;
    localparam int LED_LSB   = 8;

endpackage

// File: rtl/led_pwm_timebase.sv
// Free-running PWM counter with duty compare, plus the blink divider that
// toggles the blink phase every BLINK_DIV PWM periods.
module led_pwm_timebase
    import led_drv_pkg::*;
#(
    parameter int PWM_W = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PWM_W-1:0] duty,
    input  logic [DIV_W-1:0] blink_div,
    input  logic             div_load,
    output logic             pwm_on,
    output logic             blink_phase
);

    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic             pwm_wrap;

    assign pwm_wrap    = &pwm_cnt_q;
    // All-ones duty is treated as 100% so no cycle is dropped at the wrap.
    assign pwm_on      = (pwm_cnt_q < duty) || (&duty);
    assign blink_phase = blink_phase_q;

    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + PWM_W'(1);
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (div_load || (blink_div == '0)) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (pwm_wrap) begin
            if (blink_cnt_q == blink_div - DIV_W'(1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

endmodule

// File: rtl/led_pwm_blink_driver.sv
// LED pin driver: Avalon-MM register file, PWM/blink timebase and a two-stage
// pattern pipeline from the LED PIO to the pins.
module led_pwm_blink_driver
    import led_drv_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PWM_W    = 8,
    parameter int DIV_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] led_pattern,
    output logic [NUM_LEDS-1:0] led_out
);

    logic [PWM_W-1:0]    duty_q, duty_d;
    logic [DIV_W-1:0]    blink_div_q, blink_div_d;
    logic [NUM_LEDS-1:0] blink_mask_q, blink_mask_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [NUM_LEDS-1:0] led_out_q, led_out_d;
    logic                wr_en;
    logic                div_load;
    logic                pwm_on;
    logic                blink_phase;
    logic                unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign div_load     = wr_en && (address == ADDR_BLINK_DIV);
    assign unused_wdata = ^writedata;
    assign led_out      = led_out_q;

    led_pwm_timebase #(
        .PWM_W (PWM_W),
        .DIV_W (DIV_W)
    ) u_timebase (
        .clk         (clk),
        .reset_n     (reset_n),
        .duty        (duty_q),
        .blink_div   (blink_div_q),
        .div_load    (div_load),
        .pwm_on      (pwm_on),
        .blink_phase (blink_phase)
    );

    always_comb begin
        duty_d       = duty_q;
        blink_div_d  = blink_div_q;
        blink_mask_d = blink_mask_q;
        if (wr_en) begin
            case (address)
                ADDR_DUTY:       duty_d       = writedata[PWM_W-1:0];
                ADDR_BLINK_DIV:  blink_div_d  = writedata[DIV_W-1:0];
                ADDR_BLINK_MASK: blink_mask_d = writedata[NUM_LEDS-1:0];
                default:         ;
            endcase
        end
    end

    // Masked LEDs follow the blink phase; unmasked ones only see PWM.
    always_comb begin
        pattern_d = led_pattern;
        led_out_d = pattern_q & {NUM_LEDS{pwm_on}} & (~blink_mask_q | {NUM_LEDS{blink_phase}});
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DUTY:       readdata[PWM_W-1:0]    = duty_q;
            ADDR_BLINK_DIV:  readdata[DIV_W-1:0]    = blink_div_q;
            ADDR_BLINK_MASK: readdata[NUM_LEDS-1:0] = blink_mask_q;
            default: begin
                readdata[PHASE_BIT]           = blink_phase;
                readdata[LED_LSB +: NUM_LEDS] = led_out_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q       <= DUTY_RST[PWM_W-1:0];
            blink_div_q  <= BLINK_DIV_RST[DIV_W-1:0];
            blink_mask_q <= BLINK_MASK_RST[NUM_LEDS-1:0];
            pattern_q    <= '0;
            led_out_q    <= '0;
        end else begin
            duty_q       <= duty_d;
            blink_div_q  <= blink_div_d;
            blink_mask_q <= blink_mask_d;
            pattern_q    <= pattern_d;
            led_out_q    <= led_out_d;
        end
    end

endmodule
